// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slew-rate limited duty ramp between the command path and the PWM stage
module pwm_duty_ramp #(
  parameter int STEP_CYCLES = 50000,
  parameter int STEP        = 1,
  parameter int MAX_DUTY    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  input  logic       estop,
  output logic [7:0] duty_cycle,
  output logic       at_target,
  output logic       busy,
  output logic       clamp_err
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] MAX8  = 8'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [7:0]    target;
  logic [7:0]    cmd_buf;
  logic [7:0]    target_load;
  logic [7:0]    duty_step;
  logic [7:0]    duty_next;
  logic [8:0]    duty9, target9, up_sum, down_floor;
  logic          accept, tick, clamp_hit;

  assign accept      = cmd_valid && cmd_ready;
  assign tick        = (state == RAMP) && (cnt == CNT_MAX);
  assign clamp_hit   = (cmd_buf > MAX8);
  assign target_load = clamp_hit ? MAX8 : cmd_buf;
  assign duty9       = {1'b0, duty_cycle};
  assign target9     = {1'b0, target};
  assign up_sum      = duty9 + STEP9;
  assign down_floor  = target9 + STEP9;

  // 9-bit arithmetic so a step can never wrap past the target in either direction
  always_comb begin
    duty_step = duty_cycle;
    if (duty_cycle < target) begin
      duty_step = (up_sum >= target9) ? target : up_sum[7:0];
    end else if (duty_cycle > target) begin
      duty_step = (duty9 <= down_floor) ? target : duty_cycle - STEP9[7:0];
    end
  end

  assign duty_next = tick ? duty_step : duty_cycle;

  always_ff @(posedge clk) begin
    if (reset || estop) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = (target_load != duty_cycle) ? RAMP : IDLE;
      RAMP: begin
        if (accept) begin
          state_next = LOAD;
        end else if (duty_next == target) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = !estop && (state != LOAD);
    busy      = (state == RAMP);
    at_target = (duty_cycle == target) && (state != LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset || estop) begin
      duty_cycle <= 8'd0;
      target     <= 8'd0;
      cnt        <= '0;
      clamp_err  <= 1'b0;
      cmd_buf    <= 8'd0;
    end else begin
      clamp_err <= 1'b0;
      if (accept) begin
        cmd_buf <= cmd_duty;
      end
      case (state)
        LOAD: begin
          target    <= target_load;
          clamp_err <= clamp_hit;
          cnt       <= '0;
        end
        RAMP: begin
          // a retarget preempts the step; the new ramp starts from the present duty
          if (accept) begin
            cnt <= '0;
          end else begin
            cnt        <= tick ? '0 : cnt + CW'(1);
            duty_cycle <= duty_next;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - directed self-checking bench for pwm_duty_ramp
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready;
  logic       estop;
  logic [7:0] duty_cycle;
  logic       at_target;
  logic       busy;
  logic       clamp_err;

  int total  = 0;
  int passed = 0;

  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP(10), .MAX_DUTY(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_duty  (cmd_duty),
    .cmd_ready (cmd_ready),
    .estop     (estop),
    .duty_cycle(duty_cycle),
    .at_target (at_target),
    .busy      (busy),
    .clamp_err (clamp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // leaves the DUT in LOAD, one clock after the accept edge
  task automatic send(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_duty = 8'd0; estop = 1'b0;
    ticks(2);
    reset = 1'b0;
    #1;
    chk("rst_duty", duty_cycle, 0);
    chk("rst_at_target", at_target, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clamp", clamp_err, 0);

    // ramp 0 -> 35
    send(8'd35);
    chk("t2_load_ready", cmd_ready, 0);
    chk("t2_load_at_target", at_target, 0);
    tick();
    chk("t2_busy", busy, 1);
    chk("t2_duty_e1", duty_cycle, 0);
    ticks(3);
    chk("t2_duty_e4", duty_cycle, 0);
    tick();
    chk("t2_step1", duty_cycle, 10);
    ticks(4);
    chk("t2_step2", duty_cycle, 20);
    ticks(4);
    chk("t2_step3", duty_cycle, 30);
    ticks(4);
    chk("t2_step4", duty_cycle, 35);
    chk("t2_done_busy", busy, 0);
    chk("t2_done_at_target", at_target, 1);

    // clamp 200 -> 100
    send(8'd200);
    tick();
    chk("t3_clamp_pulse", clamp_err, 1);
    tick();
    chk("t3_clamp_clear", clamp_err, 0);
    ticks(23);
    chk("t3_duty_95", duty_cycle, 95);
    ticks(4);
    chk("t3_duty_100", duty_cycle, 100);
    chk("t3_busy", busy, 0);
    ticks(8);
    chk("t3_hold_100", duty_cycle, 100);

    // reversal mid-ramp
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_reset_duty", duty_cycle, 0);
    send(8'd90);
    tick();
    ticks(20);
    chk("t4_duty_50", duty_cycle, 50);
    chk("t4_busy", busy, 1);
    send(8'd20);
    chk("t4_load_duty", duty_cycle, 50);
    chk("t4_load_ready", cmd_ready, 0);
    tick();
    ticks(4);
    chk("t4_duty_40", duty_cycle, 40);
    ticks(4);
    chk("t4_duty_30", duty_cycle, 30);
    ticks(4);
    chk("t4_duty_20", duty_cycle, 20);
    chk("t4_busy_done", busy, 0);
    chk("t4_at_target", at_target, 1);

    // estop at 60 with a held command
    send(8'd90);
    tick();
    ticks(16);
    chk("t5_duty_60", duty_cycle, 60);
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd70;
    #1;
    chk("t5_ready_estop", cmd_ready, 0);
    tick();
    chk("t5_duty_0", duty_cycle, 0);
    chk("t5_busy", busy, 0);
    ticks(3);
    chk("t5_hold_duty", duty_cycle, 0);
    chk("t5_hold_ready", cmd_ready, 0);
    estop = 1'b0;
    #1;
    chk("t5_release_ready", cmd_ready, 1);
    tick();
    chk("t5_accepted", cmd_ready, 0);
    cmd_valid = 1'b0;
    tick();
    chk("t5_ramp_busy", busy, 1);
    ticks(4);
    chk("t5_duty_10", duty_cycle, 10);

    // reset mid-ramp, then a command equal to the current duty
    reset = 1'b1;
    tick();
    chk("t6_reset_duty", duty_cycle, 0);
    chk("t6_reset_busy", busy, 0);
    reset = 1'b0;
    send(8'd0);
    chk("t6_load_busy", busy, 0);
    chk("t6_load_at_target", at_target, 0);
    tick();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_at_target", at_target, 1);
    chk("t6_idle_ready", cmd_ready, 1);
    ticks(5);
    chk("t6_duty_hold", duty_cycle, 0);
    chk("t6_busy_hold", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
